// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 core and its program loader.
// HLT_WORD is the end-of-program marker and the value used to pad unused memory.
// The loader state enum is also visible to any debug/monitor logic.
package mips_pkg;

  localparam logic [5:0]  HLT_OPCODE = 6'h3f;
  localparam logic [31:0] HLT_WORD   = {HLT_OPCODE, 26'd0};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    INIT,
    RUN
  } ld_state_e;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams 32-bit words into consecutive instruction-memory
// addresses, optionally pads the tail with HLT, pulses core_init, then holds core_run.
// Latency: a word accepted in one cycle appears on mem_we/mem_addr/mem_wdata the next.
// Backpressure: s_ready is high only in LOAD (and not during abort); words are
// consumed on s_valid & s_ready, never outside LOAD.
// Ports:
//   clk1, rst_n                 clock, async active-low reset
//   start, abort                control (abort wins over start)
//   s_valid, s_data, s_ready    input word stream
//   mem_we, mem_addr, mem_wdata registered memory write port
//   core_init, core_run, busy   core control and status
//   word_count, checksum        words accepted (HLT included) and XOR of them
//   err_overflow                sticky: memory filled without HLT; cleared by start
module prog_loader #(
  parameter int          ADDR_W   = 5,
  parameter int          DEPTH    = 1 << ADDR_W,
  parameter logic [31:0] HLT_WORD = mips_pkg::HLT_WORD,
  parameter bit          PAD_EN   = 1'b1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_init,
  output logic              core_run,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum,
  output logic              err_overflow
);
  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [31:0]       csum_q, csum_d;
  logic              err_q, err_d;
  logic              init_ph_q, init_ph_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              accept;

  // Gating with abort means no word is consumed in the cycle that aborts.
  assign s_ready = (state_q == LOAD) && !abort;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    err_d     = err_q;
    init_ph_d = 1'b0;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (start) begin
            state_d = LOAD;
            addr_d  = '0;
            cnt_d   = '0;
            csum_d  = '0;
            err_d   = 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = s_data;
            cnt_d   = cnt_q + 1'b1;
            csum_d  = csum_q ^ s_data;
            // Address saturates at LAST; every exit from LAST leaves LOAD.
            if (addr_q != LAST) addr_d = addr_q + 1'b1;
            if (s_data == HLT_WORD) begin
              state_d = (PAD_EN && (addr_q != LAST)) ? PAD : INIT;
            end else if (addr_q == LAST) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        PAD: begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = HLT_WORD;
          if (addr_q == LAST) state_d = INIT;
          else                addr_d  = addr_q + 1'b1;
        end
        INIT: begin
          // Two phases: the first lets the last registered write land,
          // the second drives core_init with no write in flight.
          if (init_ph_q) state_d   = RUN;
          else           init_ph_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
      err_q     <= 1'b0;
      init_ph_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      err_q     <= err_d;
      init_ph_q <= init_ph_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_addr     = waddr_q;
  assign mem_wdata    = wdata_q;
  assign core_init    = (state_q == INIT) && init_ph_q;
  assign core_run     = (state_q == RUN);
  assign busy         = (state_q == LOAD) || (state_q == PAD) || (state_q == INIT);
  assign word_count   = cnt_q;
  assign checksum     = csum_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam logic [31:0] HLT = 32'hfc000000;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  // 16-deep instance
  logic        start = 0, abort = 0, s_valid = 0;
  logic [31:0] s_data = 0;
  logic        s_ready, mem_we, core_init, core_run, busy, err_overflow;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata, checksum;
  logic [4:0]  word_count;

  // 4-deep instance
  logic        start4 = 0, abort4 = 0, s_valid4 = 0;
  logic [31:0] s_data4 = 0;
  logic        s_ready4, mem_we4, core_init4, core_run4, busy4, err4;
  logic [1:0]  mem_addr4;
  logic [31:0] mem_wdata4, checksum4;
  logic [2:0]  word_count4;

  prog_loader #(.ADDR_W(4), .DEPTH(16)) u_dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_init(core_init), .core_run(core_run), .busy(busy),
    .word_count(word_count), .checksum(checksum), .err_overflow(err_overflow)
  );

  prog_loader #(.ADDR_W(2), .DEPTH(4)) u_dut4 (
    .clk1(clk1), .rst_n(rst_n), .start(start4), .abort(abort4),
    .s_valid(s_valid4), .s_data(s_data4), .s_ready(s_ready4),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .core_init(core_init4), .core_run(core_run4), .busy(busy4),
    .word_count(word_count4), .checksum(checksum4), .err_overflow(err4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: {addr, data} of every write the loader is expected to issue.
  logic [35:0] exp_q[$];
  logic [33:0] exp4_q[$];
  logic [31:0] img[16];
  int          wr_cnt = 0, init_cnt = 0, init4_cnt = 0;
  logic        prev_we = 0;

  always @(negedge clk1) begin
    logic [35:0] e;
    if (mem_we) begin
      wr_cnt++;
      img[mem_addr] = mem_wdata;
      if (exp_q.size() == 0) check_val("spurious_we", mem_we, 0);
      else begin
        e = exp_q.pop_front();
        check_val("wr_addr", mem_addr, e[35:32]);
        check_val("wr_data", mem_wdata, e[31:0]);
      end
    end
    if (core_init) begin
      init_cnt++;
      check_val("init_no_we", mem_we, 0);
      check_val("init_prev_we", prev_we, 1);
      check_val("init_no_run", core_run, 0);
    end
    prev_we = mem_we;
  end

  always @(negedge clk1) begin
    logic [33:0] e4;
    if (mem_we4) begin
      if (exp4_q.size() == 0) check_val("spurious_we4", mem_we4, 0);
      else begin
        e4 = exp4_q.pop_front();
        check_val("wr4_addr", mem_addr4, e4[33:32]);
        check_val("wr4_data", mem_wdata4, e4[31:0]);
      end
    end
    if (core_init4) init4_cnt++;
  end

  // Bench model of the 16-deep loader
  int          exp_addr;
  int          cnt_exp;
  logic [31:0] csum_exp;

  task automatic begin_load();
    start = 1;
    @(negedge clk1);
    start = 0;
    exp_addr = 0;
    cnt_exp  = 0;
    csum_exp = 0;
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      s_valid = 0;
      s_data  = $urandom;
      @(negedge clk1);
    end
    s_valid = 1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk1);
      n++;
    end
    if (!s_ready) begin
      check_val("send_timeout", s_ready, 1);
      s_valid = 0;
      return;
    end
    exp_q.push_back({4'(exp_addr), d});
    csum_exp ^= d;
    cnt_exp++;
    if (d == HLT)
      for (int a = exp_addr + 1; a < 16; a++) exp_q.push_back({4'(a), HLT});
    exp_addr++;
    @(negedge clk1);
    s_valid = 0;
    s_data  = $urandom;
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (!core_run && n < 100) begin
      @(negedge clk1);
      n++;
    end
    check_val(tag, core_run, 1);
  endtask

  logic [31:0] prog[9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                           32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                           32'hfc000000};

  task automatic check_image(input string tag);
    for (int a = 0; a < 16; a++)
      check_val(tag, img[a], (a < 9) ? {32'd0, prog[a]} : {32'd0, HLT});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base_init, base_wr;
    logic [31:0] csum_ref;

    // Reset values
    @(negedge clk1);
    check_val("rst_we", mem_we, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_init_run", {core_init, core_run, busy, s_ready, err_overflow}, 0);
    check_val("rst_count", word_count, 0);
    check_val("rst_csum", checksum, 0);
    rst_n = 1;
    @(negedge clk1);
    check_val("idle_rdy", s_ready, 0);

    // 1: back-to-back stream with padding
    csum_ref = 0;
    foreach (prog[i]) csum_ref ^= prog[i];
    begin_load();
    check_val("t1_busy", busy, 1);
    check_val("t1_rdy", s_ready, 1);
    foreach (prog[i]) send(prog[i], 0);
    wait_run("t1_run");
    check_val("t1_init_cnt", init_cnt, 1);
    check_val("t1_count", word_count, 9);
    check_val("t1_csum", checksum, csum_ref);
    check_val("t1_csum_model", checksum, csum_exp);
    check_val("t1_pending", exp_q.size(), 0);
    check_val("t1_writes", wr_cnt, 16);
    check_image("t1_img");

    // 2: reload from RUN with valid gaps
    foreach (img[a]) img[a] = 32'hdeadbeef;
    base_init = init_cnt;
    begin_load();
    check_val("t2_run_drop", core_run, 0);
    check_val("t2_busy", busy, 1);
    foreach (prog[i]) send(prog[i], $urandom_range(0, 3));
    wait_run("t2_run");
    check_val("t2_init_cnt", init_cnt - base_init, 1);
    check_val("t2_count", word_count, 9);
    check_val("t2_csum", checksum, csum_ref);
    check_val("t2_pending", exp_q.size(), 0);
    check_image("t2_img");

    // 3: overflow on the 4-deep instance
    start4 = 1;
    @(negedge clk1);
    start4 = 0;
    for (int i = 0; i < 4; i++) begin
      s_valid4 = 1;
      s_data4  = 32'h0bad0000 + 32'(i);
      n = 0;
      while (!s_ready4 && n < 20) begin
        @(negedge clk1);
        n++;
      end
      check_val("t3_rdy", s_ready4, 1);
      exp4_q.push_back({2'(i), s_data4});
      @(negedge clk1);
      s_valid4 = 0;
    end
    check_val("t3_err", err4, 1);
    check_val("t3_idle", {busy4, core_run4, s_ready4}, 0);
    check_val("t3_count", word_count4, 4);
    s_valid4 = 1;
    s_data4  = 32'h12345678;
    repeat (3) @(negedge clk1);
    check_val("t3_fifth_rdy", s_ready4, 0);
    s_valid4 = 0;
    @(negedge clk1);
    check_val("t3_fifth_count", word_count4, 4);
    check_val("t3_no_init", init4_cnt, 0);
    check_val("t3_pending", exp4_q.size(), 0);
    check_val("t3_err_sticky", err4, 1);
    start4 = 1;
    @(negedge clk1);
    start4 = 0;
    check_val("t3_err_clear", err4, 0);
    abort4 = 1;
    @(negedge clk1);
    abort4 = 0;

    // 4: abort after 3 accepted words
    begin_load();
    for (int i = 0; i < 3; i++) send(32'h00a00000 + 32'(i), 0);
    base_wr = wr_cnt;
    abort = 1;
    @(negedge clk1);
    abort = 0;
    check_val("t4_idle_busy", busy, 0);
    check_val("t4_idle_rdy", s_ready, 0);
    check_val("t4_run", core_run, 0);
    s_valid = 1;
    s_data  = 32'h55555555;
    repeat (4) @(negedge clk1);
    s_valid = 0;
    check_val("t4_extra_we_le1", (wr_cnt - base_wr) <= 1, 1);
    check_val("t4_pending", exp_q.size(), 0);
    check_val("t4_count", word_count, 3);

    // 5: reset in the middle of PAD
    begin_load();
    send(32'h11111111, 0);
    send(HLT, 0);
    repeat (3) @(negedge clk1);
    #2 rst_n = 0;
    #1;
    check_val("t5_rst_we", mem_we, 0);
    check_val("t5_rst_busy", busy, 0);
    check_val("t5_rst_addr", mem_addr, 0);
    check_val("t5_rst_wdata", mem_wdata, 0);
    check_val("t5_rst_count", word_count, 0);
    check_val("t5_rst_csum", checksum, 0);
    exp_q.delete();
    @(negedge clk1);
    rst_n = 1;
    @(negedge clk1);
    base_init = init_cnt;
    begin_load();
    send(32'h0000000a, 1);
    send(32'h0000000b, 0);
    send(HLT, 2);
    wait_run("t5_run");
    check_val("t5_init_cnt", init_cnt - base_init, 1);
    check_val("t5_count", word_count, 3);
    check_val("t5_csum", checksum, 32'h0000000a ^ 32'h0000000b ^ HLT);
    check_val("t5_pending", exp_q.size(), 0);

    // 6: start and abort together in RUN
    start = 1;
    abort = 1;
    @(negedge clk1);
    start = 0;
    abort = 0;
    check_val("t6_run", core_run, 0);
    check_val("t6_busy", busy, 0);
    check_val("t6_rdy", s_ready, 0);
    @(negedge clk1);
    check_val("t6_busy_later", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
